axi_lite_data_master: RTL and testbench

Core-side AXI-lite initiator for the data port. Accepts single load/store requests from the load-store unit, drives the AR/R and AW/W channels toward the data RAM, and returns one response per request. The RAM side has no write strobes and no B channel, so this block handles byte and halfword stores internally by read-modify-write. It also sign- or zero-extends sub-word loads.

---
 rtl/axi_lite_data_master.sv | 172 +++++++++++++++++
 tb/tb_axi_lite_data_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_data_master.sv
// Core-side AXI-lite data-port initiator: single outstanding load/store, sub-word
// stores done as read-modify-write because the RAM has no strobes or B channel.
module axi_lite_data_master #(
    parameter int DATA_WIDTH = 32,
    parameter bit WORD_ADDR  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [31:0]           ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic [31:0]           AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        MERGE,
        WR,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    ready_q;
    logic                    isStore_q;
    logic [1:0]              size_q;
    logic                    zeroExt_q;
    logic                    err_q;
    logic [31:0]             addr_q;
    logic [DATA_WIDTH-1:0]   busWdata_q;
    logic [DATA_WIDTH-1:0]   readWord_q;
    logic                    awDone_q;
    logic                    wDone_q;

    logic                    reqErr;
    logic [DATA_WIDTH-1:0]   mergedWord;
    logic [31:0]             loadData;
    logic [7:0]              loadByte;
    logic [15:0]             loadHalf;

    assign reqErr = (req_size == 2'd3)
                  || ((req_size == 2'd1) && req_addr[0])
                  || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    // Next-state decode; AXI inputs only steer transitions, never outputs directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (reqErr)
                        state_d = RESP;
                    else if (!req_we || (req_size != 2'd2))
                        state_d = RD_ADDR;
                    else
                        state_d = WR;
                end
            end
            RD_ADDR: if (ARREADY) state_d = RD_DATA;
            RD_DATA: if (RVALID) state_d = isStore_q ? MERGE : RESP;
            MERGE:   state_d = WR;
            WR:      if ((awDone_q || AWREADY) && (wDone_q || WREADY)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mergedWord = readWord_q;
        if (size_q == 2'd0) begin
            case (addr_q[1:0])
                2'd0:    mergedWord[7:0]   = busWdata_q[7:0];
                2'd1:    mergedWord[15:8]  = busWdata_q[7:0];
                2'd2:    mergedWord[23:16] = busWdata_q[7:0];
                default: mergedWord[31:24] = busWdata_q[7:0];
            endcase
        end else begin
            if (addr_q[1])
                mergedWord[31:16] = busWdata_q[15:0];
            else
                mergedWord[15:0]  = busWdata_q[15:0];
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    loadByte = readWord_q[7:0];
            2'd1:    loadByte = readWord_q[15:8];
            2'd2:    loadByte = readWord_q[23:16];
            default: loadByte = readWord_q[31:24];
        endcase
        loadHalf = addr_q[1] ? readWord_q[31:16] : readWord_q[15:0];
        case (size_q)
            2'd0:    loadData = zeroExt_q ? {24'b0, loadByte} : {{24{loadByte[7]}}, loadByte};
            2'd1:    loadData = zeroExt_q ? {16'b0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
            default: loadData = readWord_q;
        endcase
    end

    // Request latch, read capture, merge and write-handshake tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            isStore_q  <= 1'b0;
            size_q     <= 2'd0;
            zeroExt_q  <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            busWdata_q <= '0;
            readWord_q <= '0;
            awDone_q   <= 1'b0;
            wDone_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        isStore_q  <= req_we;
                        size_q     <= req_size;
                        zeroExt_q  <= req_unsigned;
                        err_q      <= reqErr;
                        addr_q     <= req_addr;
                        busWdata_q <= req_wdata;
                        awDone_q   <= 1'b0;
                        wDone_q    <= 1'b0;
                    end
                end
                RD_DATA: if (RVALID) readWord_q <= RDATA;
                MERGE:   busWdata_q <= mergedWord;
                WR: begin
                    if (AWREADY) awDone_q <= 1'b1;
                    if (WREADY)  wDone_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign ARVALID   = (state_q == RD_ADDR);
    assign RREADY    = (state_q == RD_DATA);
    assign AWVALID   = (state_q == WR) && !awDone_q;
    assign WVALID    = (state_q == WR) && !wDone_q;
    assign ARADDR    = WORD_ADDR ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
    assign AWADDR    = ARADDR;
    assign WDATA     = busWdata_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = ((state_q == RESP) && !isStore_q && !err_q) ? loadData : 32'd0;

endmodule

// File: tb/tb_axi_lite_data_master.sv
// Scoreboard bench for axi_lite_data_master: directed requests against a reactive
// AXI-lite slave with per-request stall counts.
module tb_axi_lite_data_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] RDATA = '0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY = 1'b0;

    axi_lite_data_master #(.DATA_WIDTH(32), .WORD_ADDR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nAr;
        int          nAw;
        int          nW;
        logic [31:0] arAddr;
        logic [31:0] awAddr;
        logic [31:0] wData;
    } exp_t;

    exp_t expQ[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int arStall = 0, rStall = 0, awStall = 0, wStall = 0;
    logic [31:0] slaveWord = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic [31:0] rdata, input int lat,
                                input int nAr, input int nAw, input int nW,
                                input logic [31:0] arAddr, input logic [31:0] awAddr,
                                input logic [31:0] wData);
        exp_t e;
        e.err = err; e.rdata = rdata; e.lat = lat;
        e.nAr = nAr; e.nAw = nAw; e.nW = nW;
        e.arAddr = arAddr; e.awAddr = awAddr; e.wData = wData;
        return e;
    endfunction

    // Reactive slave: each READY/VALID rises after its programmed number of stall cycles.
    initial begin
        int arCnt = 0, rCnt = 0, awCnt = 0, wCnt = 0;
        forever begin
            @(negedge clk);
            if (ARVALID !== 1'b1) begin arCnt = 0; ARREADY = 1'b0; end
            else begin ARREADY = (arCnt >= arStall); arCnt++; end
            if (RREADY !== 1'b1) begin rCnt = 0; RVALID = 1'b0; RDATA = '0; end
            else begin
                RVALID = (rCnt >= rStall);
                RDATA  = RVALID ? slaveWord : 32'd0;
                rCnt++;
            end
            if (AWVALID !== 1'b1) begin awCnt = 0; AWREADY = 1'b0; end
            else begin AWREADY = (awCnt >= awStall); awCnt++; end
            if (WVALID !== 1'b1) begin wCnt = 0; WREADY = 1'b0; end
            else begin WREADY = (wCnt >= wStall); wCnt++; end
        end
    end

    // Monitor: tracks handshakes per request, checks VALID stability and pops the scoreboard.
    initial begin
        int acceptEdge = 0, nAr = 0, nAw = 0, nW = 0, awEdge = 0, wEdge = 0, lastWr = 0;
        logic [31:0] seenAr = '0, seenAw = '0, seenW = '0;
        logic pArV = 0, pArR = 0, pAwV = 0, pAwR = 0, pWV = 0, pWR = 0;
        logic [31:0] pArA = '0, pAwA = '0, pWD = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b1) begin
                if (req_valid && req_ready) begin
                    acceptEdge = cyc + 1;
                    nAr = 0; nAw = 0; nW = 0; awEdge = 0; wEdge = 0;
                end
                if (pArV && !pArR) begin
                    checkOutput("ARVALID_held", {31'd0, ARVALID}, 32'd1);
                    checkOutput("ARADDR_held", ARADDR, pArA);
                end
                if (pAwV && !pAwR) begin
                    checkOutput("AWVALID_held", {31'd0, AWVALID}, 32'd1);
                    checkOutput("AWADDR_held", AWADDR, pAwA);
                end
                if (pWV && !pWR) begin
                    checkOutput("WVALID_held", {31'd0, WVALID}, 32'd1);
                    checkOutput("WDATA_held", WDATA, pWD);
                end
                if (ARVALID && ARREADY) begin nAr++; seenAr = ARADDR; end
                if (AWVALID && AWREADY) begin nAw++; seenAw = AWADDR; awEdge = cyc + 1; end
                if (WVALID && WREADY)   begin nW++;  seenW = WDATA;   wEdge = cyc + 1; end
                if (rsp_valid === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_rsp actual=rsp_valid expected=none");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                        checkOutput("latency", 32'(cyc + 1 - acceptEdge), 32'(e.lat));
                        checkOutput("ar_count", 32'(nAr), 32'(e.nAr));
                        checkOutput("aw_count", 32'(nAw), 32'(e.nAw));
                        checkOutput("w_count", 32'(nW), 32'(e.nW));
                        if (e.nAr > 0) checkOutput("ARADDR", seenAr, e.arAddr);
                        if (e.nAw > 0) begin
                            checkOutput("AWADDR", seenAw, e.awAddr);
                            checkOutput("WDATA", seenW, e.wData);
                            lastWr = (awEdge > wEdge) ? awEdge : wEdge;
                            checkOutput("rsp_after_write", 32'(cyc + 1 - lastWr), 32'd1);
                        end
                    end
                end
                pArV = ARVALID; pArR = ARREADY; pArA = ARADDR;
                pAwV = AWVALID; pAwR = AWREADY; pAwA = AWADDR;
                pWV  = WVALID;  pWR  = WREADY;  pWD  = WDATA;
            end else begin
                pArV = 0; pArR = 0; pAwV = 0; pAwR = 0; pWV = 0; pWR = 0;
            end
        end
    end

    task applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] word, input int arS, input int rS,
                       input int awS, input int wS, input exp_t e);
        int n;
        slaveWord = word;
        arStall = arS; rStall = rS; awStall = awS; wStall = wS;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout actual=%b expected=1", req_ready);
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        expQ.push_back(e);
        n = 0;
        while (expQ.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_timeout actual=pending%0d expected=0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("reset_valids", {27'd0, ARVALID, RREADY, AWVALID, WVALID, rsp_valid}, 32'd0);
        checkOutput("reset_ARADDR", ARADDR, 32'd0);
        checkOutput("reset_WDATA", WDATA, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_req_ready", {31'd0, req_ready}, 32'd1);

        applyStimulus(0, 2'd2, 0, 32'h10, 0, 32'hDEADBEEF, 0, 0, 0, 0,
                      mk(0, 32'hDEADBEEF, 3, 1, 0, 0, 32'h4, 0, 0));
        applyStimulus(0, 2'd0, 0, 32'h13, 0, 32'h80FF0000, 0, 0, 0, 0,
                      mk(0, 32'hFFFFFF80, 3, 1, 0, 0, 32'h4, 0, 0));
        applyStimulus(0, 2'd0, 1, 32'h13, 0, 32'h80FF0000, 0, 0, 0, 0,
                      mk(0, 32'h00000080, 3, 1, 0, 0, 32'h4, 0, 0));
        applyStimulus(0, 2'd1, 0, 32'h12, 0, 32'h80FF0000, 0, 0, 0, 0,
                      mk(0, 32'hFFFF80FF, 3, 1, 0, 0, 32'h4, 0, 0));
        applyStimulus(0, 2'd1, 1, 32'h12, 0, 32'h80FF0000, 0, 0, 0, 0,
                      mk(0, 32'h000080FF, 3, 1, 0, 0, 32'h4, 0, 0));
        applyStimulus(0, 2'd0, 0, 32'h11, 0, 32'h12345678, 0, 0, 0, 0,
                      mk(0, 32'h00000056, 3, 1, 0, 0, 32'h4, 0, 0));
        applyStimulus(0, 2'd0, 0, 32'h12, 0, 32'h12F45678, 0, 0, 0, 0,
                      mk(0, 32'hFFFFFFF4, 3, 1, 0, 0, 32'h4, 0, 0));
        applyStimulus(1, 2'd0, 0, 32'h21, 32'hFFFFFFAA, 32'h11223344, 0, 0, 0, 0,
                      mk(0, 32'h0, 5, 1, 1, 1, 32'h8, 32'h8, 32'h1122AA44));
        applyStimulus(1, 2'd1, 0, 32'h22, 32'h1234BEEF, 32'h11223344, 0, 0, 0, 0,
                      mk(0, 32'h0, 5, 1, 1, 1, 32'h8, 32'h8, 32'hBEEF3344));
        applyStimulus(1, 2'd0, 0, 32'h23, 32'h00000055, 32'h11223344, 0, 0, 0, 0,
                      mk(0, 32'h0, 5, 1, 1, 1, 32'h8, 32'h8, 32'h55223344));
        applyStimulus(1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0, 0, 0,
                      mk(0, 32'h0, 2, 0, 1, 1, 0, 32'h10, 32'hCAFEF00D));
        applyStimulus(1, 2'd2, 0, 32'h44, 32'hA5A50F0F, 32'h0, 0, 0, 3, 1,
                      mk(0, 32'h0, 5, 0, 1, 1, 0, 32'h11, 32'hA5A50F0F));
        applyStimulus(1, 2'd2, 0, 32'h4, 32'h01020304, 32'h0, 0, 0, 0, 2,
                      mk(0, 32'h0, 4, 0, 1, 1, 0, 32'h1, 32'h01020304));
        applyStimulus(0, 2'd2, 0, 32'h8, 0, 32'h0BADF00D, 2, 2, 0, 0,
                      mk(0, 32'h0BADF00D, 7, 1, 0, 0, 32'h2, 0, 0));
        applyStimulus(0, 2'd2, 0, 32'h6, 0, 32'h0, 0, 0, 0, 0,
                      mk(1, 32'h0, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 2'd3, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0,
                      mk(1, 32'h0, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 2'd1, 0, 32'h1, 32'hFFFF, 32'h0, 0, 0, 0, 0,
                      mk(1, 32'h0, 1, 0, 0, 0, 0, 0, 0));

        // Abandon a load mid-read with reset; no response may appear for it.
        rStall = 1000;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (RREADY !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checkOutput("rd_data_reached", {31'd0, RREADY}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_valids", {29'd0, ARVALID, RREADY, rsp_valid}, 32'd0);
        checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rStall = 0;
        @(posedge clk);
        #1;
        checkOutput("postreset_req_ready", {31'd0, req_ready}, 32'd1);
        applyStimulus(0, 2'd2, 0, 32'h10, 0, 32'hDEADBEEF, 0, 0, 0, 0,
                      mk(0, 32'hDEADBEEF, 3, 1, 0, 0, 32'h4, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
